// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_timing_pkg : panel timing defaults, FSM encoding, RGB offsets   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lcd_timing_pkg;

  // 1024x600 panel defaults
  localparam int PANEL_H_ACTIVE = 1024;
  localparam int PANEL_H_FP     = 160;
  localparam int PANEL_H_SYNC   = 20;
  localparam int PANEL_H_BP     = 140;
  localparam int PANEL_V_ACTIVE = 600;
  localparam int PANEL_V_FP     = 12;
  localparam int PANEL_V_SYNC   = 3;
  localparam int PANEL_V_BP     = 20;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  // RGB888 word is {R,G,B}
  localparam int RGB_R_LSB = 16;
  localparam int RGB_G_LSB = 8;
  localparam int RGB_B_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/lcd_timing_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_timing_ctrl_if : upstream pixel stream (valid/ready + sof)      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface lcd_timing_ctrl_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [23:0] pix_data;
  logic        pix_ready;

  modport master (output pix_valid, output pix_sof, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_sof, input pix_data, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_raster_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_raster_cnt : h/v raster counters, region decode, frame_start    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_raster_cnt
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = PANEL_H_ACTIVE,
  parameter int H_FP     = PANEL_H_FP,
  parameter int H_SYNC   = PANEL_H_SYNC,
  parameter int H_BP     = PANEL_H_BP,
  parameter int V_ACTIVE = PANEL_V_ACTIVE,
  parameter int V_FP     = PANEL_V_FP,
  parameter int V_SYNC   = PANEL_V_SYNC,
  parameter int V_BP     = PANEL_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic en,
  output logic active,
  output logic hs_on,
  output logic vs_on,
  output logic origin,
  output logic frame_end,
  output logic frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  int            w_h;
  int            w_v;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h      = int'(r_h_cnt);
  assign w_v      = int'(r_v_cnt);
  assign w_h_last = (w_h == H_TOTAL - 1);
  assign w_v_last = (w_v == V_TOTAL - 1);

  assign active    = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign hs_on     = (w_h >= HS_START) && (w_h < HS_END);
  assign vs_on     = (w_v >= VS_START) && (w_v < VS_END);
  assign origin    = (w_h == 0) && (w_v == 0);
  assign frame_end = w_h_last && w_v_last;

  // Counters sit at the origin while disabled so a new frame starts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= cnt_en & en & origin;
      if (!cnt_en) begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end else if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_timing_ctrl : raster timing + frame-locked pixel feed to LVDS   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = PANEL_H_ACTIVE,
  parameter int H_FP     = PANEL_H_FP,
  parameter int H_SYNC   = PANEL_H_SYNC,
  parameter int H_BP     = PANEL_H_BP,
  parameter int V_ACTIVE = PANEL_V_ACTIVE,
  parameter int V_FP     = PANEL_V_FP,
  parameter int V_SYNC   = PANEL_V_SYNC,
  parameter int V_BP     = PANEL_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr_err,
  lcd_timing_ctrl_if.slave         pix,
  output logic                     lcd_vs,
  output logic                     lcd_hs,
  output logic                     lcd_de,
  output logic [7:0]               lcd_red,
  output logic [7:0]               lcd_green,
  output logic [7:0]               lcd_blue,
  output logic                     frame_start,
  output logic                     underflow,
  output logic                     sync_err
);

  logic [1:0] r_state;
  logic [1:0] w_state_nx;
  logic       w_active;
  logic       w_hs_on;
  logic       w_vs_on;
  logic       w_origin;
  logic       w_frame_end;
  logic       w_running;
  logic       w_sof_here;
  logic       w_lock;
  logic       w_bad_sof;
  logic       w_uf;
  logic       w_ready;
  logic       w_show;

  lcd_raster_cnt #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_en      (w_running),
    .en          (en),
    .active      (w_active),
    .hs_on       (w_hs_on),
    .vs_on       (w_vs_on),
    .origin      (w_origin),
    .frame_end   (w_frame_end),
    .frame_start (frame_start)
  );

  assign w_running  = (r_state != ST_IDLE);
  assign w_sof_here = pix.pix_valid & pix.pix_sof;
  assign w_lock     = (r_state == ST_WAIT_SOF) & w_sof_here & w_origin;
  assign w_bad_sof  = (r_state == ST_RUN) & w_active & w_sof_here & ~w_origin;
  assign w_uf       = (r_state == ST_RUN) & w_active & ~pix.pix_valid;

  // While hunting for SOF, non-SOF pixels are drained; the SOF pixel waits for the origin.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_WAIT_SOF: w_ready = pix.pix_valid & (~pix.pix_sof | w_origin);
      ST_RUN:      w_ready = w_active & ~(w_sof_here & ~w_origin);
      default:     w_ready = 1'b0;
    endcase
  end

  assign pix.pix_ready = w_ready;
  assign w_show = pix.pix_valid & w_ready & w_active & ((r_state == ST_RUN) | w_lock);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:     if (en)                w_state_nx = ST_WAIT_SOF;
      ST_WAIT_SOF: if (w_lock)            w_state_nx = ST_RUN;
      ST_RUN:      if (w_uf | w_bad_sof)  w_state_nx = ST_WAIT_SOF;
      default:                            w_state_nx = ST_IDLE;
    endcase
    // A disabled raster always finishes the frame it is in before going idle.
    if (w_running && w_frame_end && !en) w_state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      lcd_de    <= 1'b0;
      lcd_hs    <= ~HS_POL;
      lcd_vs    <= ~VS_POL;
      lcd_red   <= 8'h00;
      lcd_green <= 8'h00;
      lcd_blue  <= 8'h00;
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      lcd_de    <= w_running & w_active;
      lcd_hs    <= (w_running & w_hs_on) ? HS_POL : ~HS_POL;
      lcd_vs    <= (w_running & w_vs_on) ? VS_POL : ~VS_POL;
      lcd_red   <= w_show ? pix.pix_data[RGB_R_LSB +: 8] : 8'h00;
      lcd_green <= w_show ? pix.pix_data[RGB_G_LSB +: 8] : 8'h00;
      lcd_blue  <= w_show ? pix.pix_data[RGB_B_LSB +: 8] : 8'h00;
      underflow <= clr_err ? 1'b0 : (underflow | w_uf);
      sync_err  <= clr_err ? 1'b0 : (sync_err | w_bad_sof);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lcd_timing_ctrl : scoreboard bench for lcd_timing_ctrl (14x7)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lcd_timing_ctrl;

  localparam int HT = 14;
  localparam int FT = 98;
  localparam logic [29:0] RST_V = {1'b0, 1'b1, 1'b1, 24'h0, 3'b000};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic       lcd_vs, lcd_hs, lcd_de, frame_start, underflow, sync_err;
  logic [7:0] lcd_red, lcd_green, lcd_blue;

  lcd_timing_ctrl_if pif ();

  lcd_timing_ctrl #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .clr_err (clr_err), .pix (pif),
    .lcd_vs (lcd_vs), .lcd_hs (lcd_hs), .lcd_de (lcd_de),
    .lcd_red (lcd_red), .lcd_green (lcd_green), .lcd_blue (lcd_blue),
    .frame_start (frame_start), .underflow (underflow), .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] outv();
    return {lcd_de, lcd_hs, lcd_vs, lcd_red, lcd_green, lcd_blue, frame_start, underflow, sync_err};
  endfunction

  // spec-level model state
  int          m_st = 0;
  int          m_pos = 0;
  bit          m_uf = 1'b0;
  bit          m_se = 1'b0;
  logic [29:0] sb_q[$];

  // stream source
  bit src_on = 1'b0;
  int src_idx = 0;
  int junk = 0;
  int junk_acc = 0;

  // observed statistics
  int cyc = 0, n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0, n_rgb = 0, fs_last = -1, fs_period = 0;

  task automatic clear_stats();
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_rgb = 0; fs_last = -1; fs_period = 0;
  endtask

  task automatic drive(input bit gap, input bit force_sof);
    if (junk > 0) begin
      pif.pix_valid = 1'b1;
      pif.pix_sof   = 1'b0;
      pif.pix_data  = 24'hA00000 + 24'(junk);
    end else begin
      pif.pix_valid = src_on && !gap;
      pif.pix_sof   = (src_idx % 32 == 0) || force_sof;
      pif.pix_data  = 24'(src_idx);
    end
  endtask

  // One pixel clock: called at a negedge with inputs already driven.
  task automatic tick();
    int h, vl;
    bit run, act, org, rdy, take, show, ufs, ses, fs, hsa, vsa, acc;
    logic [29:0] e;
    #1;
    h   = m_pos % HT;
    vl  = m_pos / HT;
    run = (m_st != 0);
    act = run && (h < 8) && (vl < 4);
    org = (m_pos == 0);
    case (m_st)
      0:       rdy = 1'b0;
      1:       rdy = pif.pix_valid && (!pif.pix_sof || org);
      default: rdy = act && !(pif.pix_valid && pif.pix_sof && !org);
    endcase
    check_eq("ready", 32'(pif.pix_ready), 32'(rdy));
    take = pif.pix_valid && rdy;
    show = take && act && (m_st == 2 || pif.pix_sof);
    ufs  = (m_st == 2) && act && !pif.pix_valid;
    ses  = (m_st == 2) && act && pif.pix_valid && pif.pix_sof && !org;
    fs   = run && en && org;
    hsa  = run && (h >= 10) && (h < 12);
    vsa  = run && (vl == 5);
    m_uf = clr_err ? 1'b0 : (m_uf | ufs);
    m_se = clr_err ? 1'b0 : (m_se | ses);
    e = {act, !hsa, !vsa, show ? pif.pix_data : 24'h0, fs, m_uf, m_se};
    sb_q.push_back(e);
    acc = pif.pix_valid && pif.pix_ready;
    if (acc) begin
      if (junk > 0) begin junk--; junk_acc++; end
      else src_idx++;
    end
    if (m_st == 0) begin
      if (en) m_st = 1;
    end else if (m_pos == FT - 1 && !en) begin
      m_st = 0; m_pos = 0;
    end else begin
      if (m_st == 1 && take && pif.pix_sof) m_st = 2;
      else if (ufs || ses) m_st = 1;
      m_pos = (m_pos + 1) % FT;
    end
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq("out", 32'(outv()), 32'(e));
    if (lcd_de) n_de++;
    if (!lcd_hs) n_hs++;
    if (!lcd_vs) n_vs++;
    if ({lcd_red, lcd_green, lcd_blue} != 24'h0) n_rgb++;
    if (frame_start) begin
      n_fs++;
      if (fs_last >= 0) fs_period = cyc - fs_last;
      fs_last = cyc;
    end
    cyc++;
  endtask

  task automatic run_frame(input int drop_pos, input int sof_pos, input int clr_a, input int clr_b);
    for (int i = 0; i < FT; i++) begin
      clr_err = (m_pos == clr_a) || (m_pos == clr_b);
      drive(m_pos == drop_pos, m_pos == sof_pos);
      tick();
    end
    clr_err = 1'b0;
  endtask

  initial begin
    pif.pix_valid = 1'b0; pif.pix_sof = 1'b0; pif.pix_data = 24'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_out", 32'(outv()), 32'(RST_V));
    check_eq("rst_ready", 32'(pif.pix_ready), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(0, 0); tick(); end

    // free-running raster with no pixels
    en = 1'b1;
    drive(0, 0); tick();
    clear_stats();
    for (int i = 0; i < FT; i++) begin drive(0, 0); tick(); end
    check_eq("de_cnt", 32'(n_de), 32'd32);
    check_eq("hs_cnt", 32'(n_hs), 32'd14);
    check_eq("vs_cnt", 32'(n_vs), 32'd14);
    for (int i = 0; i < FT; i++) begin drive(0, 0); tick(); end
    check_eq("period", 32'(fs_period), 32'd98);
    check_eq("black", 32'(n_rgb), 32'd0);

    // stream starts mid-frame with stale pixels ahead of SOF
    for (int i = 0; i < 20; i++) begin drive(0, 0); tick(); end
    junk = 3; src_on = 1'b1; src_idx = 0;
    for (int i = 0; i < FT && m_pos != 0; i++) begin drive(0, 0); tick(); end
    check_eq("junk_flush", 32'(junk_acc), 32'd3);
    check_eq("sof_held", 32'(src_idx), 32'd0);

    // two gapless frames
    for (int i = 0; i < 2 * FT; i++) begin drive(0, 0); tick(); end
    check_eq("accepted", 32'(src_idx), 32'd64);

    // underflow at line 2 pixel 5, then relock and clear-wins-over-set
    run_frame(33, -1, -1, -1);
    check_eq("uf_flag", 32'(underflow), 32'd1);
    check_eq("uf_flush", 32'(src_idx), 32'd96);
    run_frame(33, -1, 10, 33);
    check_eq("uf_clr_win", 32'(underflow), 32'd0);
    check_eq("relock", 32'(src_idx), 32'd128);

    // stray SOF at line 0 pixel 3
    run_frame(-1, 3, -1, -1);
    check_eq("se_flag", 32'(sync_err), 32'd1);
    check_eq("se_flush", 32'(src_idx), 32'd160);

    // en dropped then restored before wrap: exit cancelled
    for (int i = 0; i < FT; i++) begin
      clr_err = (m_pos == 0);
      en = !(m_pos >= 28 && m_pos < 50);
      drive(0, 0); tick();
    end
    clr_err = 1'b0;
    clear_stats();
    for (int i = 0; i < FT; i++) begin
      en = (m_pos < 28);
      drive(0, 0); tick();
    end
    check_eq("cancel_fs", 32'(n_fs), 32'd1);
    clear_stats();
    for (int i = 0; i < 20; i++) begin drive(0, 0); tick(); end
    check_eq("idle_de", 32'(n_de), 32'd0);
    check_eq("idle_fs", 32'(n_fs), 32'd0);

    // async reset mid-line
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin drive(0, 0); tick(); end
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(outv()), 32'(RST_V));
    check_eq("rst_async_rdy", 32'(pif.pix_ready), 32'd0);
    sb_q.delete();
    m_st = 0; m_pos = 0; m_uf = 1'b0; m_se = 1'b0;
    @(negedge clk);
    check_eq("rst_hold", 32'(outv()), 32'(RST_V));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin drive(0, 0); tick(); end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
